// File: rtl/timer_defs.sv
// timer_defs: state encodings and digit constants shared by the timer entry control slice.
package timer_defs;
    localparam int DIGIT_W = 4;
    localparam logic [3:0] SEC_TENS_MAX_DEF = 4'd5;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/timer_entry_buf.sv
// timer_entry_buf: 4-digit BCD entry register, shifts valid digits in from the right.
module timer_entry_buf
    import timer_defs::*;
(
    input  logic               clk,
    input  logic               clearn,
    input  logic               shift_en,
    input  logic               clr,
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] min_t,
    output logic [DIGIT_W-1:0] min_o,
    output logic [DIGIT_W-1:0] sec_t,
    output logic [DIGIT_W-1:0] sec_o
);
    logic [4*DIGIT_W-1:0] q;
    always_ff @(posedge clk) begin
        if (!clearn || clr)
            q <= '0;
        else if (shift_en && digit <= 4'd9)
            q <= {q[3*DIGIT_W-1:0], digit};
    end
    assign {min_t, min_o, sec_t, sec_o} = q;
endmodule

// File: rtl/timer_entry_ctrl.sv
// timer_entry_ctrl: keypad entry, load strobe and tick-gated count enable for the MM:SS down-counter chain.
module timer_entry_ctrl
    import timer_defs::*;
#(
    parameter logic [3:0] SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter bit         TICK_ACTIVE  = 1'b1
) (
    input  logic               clk,
    input  logic               clearn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               start,
    input  logic               stop,
    input  logic               tick,
    input  logic               all_zero,
    output logic               loadn,
    output logic               en,
    output logic [DIGIT_W-1:0] data_min_t,
    output logic [DIGIT_W-1:0] data_min_o,
    output logic [DIGIT_W-1:0] data_sec_t,
    output logic [DIGIT_W-1:0] data_sec_o,
    output logic               running,
    output logic               done,
    output logic               err
);
    state_t state;
    logic   tick_act, bad_entry;
    assign tick_act  = tick == TICK_ACTIVE;
    assign bad_entry = {data_min_t, data_min_o, data_sec_t, data_sec_o} == '0 || data_sec_t > SEC_TENS_MAX;
    assign loadn     = state != S_LOAD;
    assign running   = state == S_RUN;
    assign done      = state == S_DONE;
    // all_zero masks the tick so the chain never wraps past 00:00
    assign en        = running & tick_act & ~all_zero;

    timer_entry_buf u_buf (
        .clk      (clk),
        .clearn   (clearn),
        .shift_en (state == S_IDLE && key_valid),
        .clr      (state == S_DONE && (start || stop)),
        .digit    (key_digit),
        .min_t    (data_min_t),
        .min_o    (data_min_o),
        .sec_t    (data_sec_t),
        .sec_o    (data_sec_o)
    );

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state <= S_IDLE;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE:  if (start) begin
                             if (bad_entry) err <= 1'b1;
                             else state <= S_LOAD;
                         end
                S_LOAD:  state <= S_RUN;
                S_RUN:   state <= all_zero ? S_DONE : stop ? S_PAUSE : S_RUN;
                S_PAUSE: state <= stop ? S_IDLE : start ? S_RUN : S_PAUSE;
                S_DONE:  state <= (start || stop) ? S_IDLE : S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_entry_ctrl.sv
// tb_timer_entry_ctrl: table-driven vectors plus hand sequences for countdown, boundary entry and mid-run reset.
module tb_timer_entry_ctrl;
    logic       clk = 1'b0;
    logic       clearn, key_valid, start, stop, tick, all_zero;
    logic [3:0] key_digit;
    logic       loadn, en, running, done, err;
    logic [3:0] data_min_t, data_min_o, data_sec_t, data_sec_o;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    timer_entry_ctrl dut (
        .clk        (clk),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .all_zero   (all_zero),
        .loadn      (loadn),
        .en         (en),
        .data_min_t (data_min_t),
        .data_min_o (data_min_o),
        .data_sec_t (data_sec_t),
        .data_sec_o (data_sec_o),
        .running    (running),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic        kv;
        logic [3:0]  kd;
        logic        st, sp, tk, az;
        logic        ld, en, run, dn, er;
        logic [15:0] bufv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                         input logic tk, input logic az);
        key_valid = kv; key_digit = kd; start = st; stop = sp; tick = tk; all_zero = az;
    endtask

    task automatic outs(input string tag, input logic ld, input logic e, input logic run,
                        input logic dn, input logic er, input logic [15:0] bufv);
        chk({tag, " loadn"},   {15'd0, loadn},   {15'd0, ld});
        chk({tag, " en"},      {15'd0, en},      {15'd0, e});
        chk({tag, " running"}, {15'd0, running}, {15'd0, run});
        chk({tag, " done"},    {15'd0, done},    {15'd0, dn});
        chk({tag, " err"},     {15'd0, err},     {15'd0, er});
        chk({tag, " buf"}, {data_min_t, data_min_o, data_sec_t, data_sec_o}, bufv);
    endtask

    task automatic step(input string tag, input logic kv, input logic [3:0] kd, input logic st,
                        input logic sp, input logic tk, input logic az, input logic ld,
                        input logic e, input logic run, input logic dn, input logic er,
                        input logic [15:0] bufv);
        drive(kv, kd, st, sp, tk, az);
        @(negedge clk);
        outs(tag, ld, e, run, dn, er, bufv);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        clearn = 1'b0;
        @(posedge clk); #1;
        clearn = 1'b1;
    endtask

    initial begin
        int cnt, pulses;
        //                 kv kd    st sp tk az  ld en rn dn er  buf
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{1, 4'd1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{1, 4'd2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0001});
        vecs.push_back('{1, 4'd3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0012});
        vecs.push_back('{1, 4'd4, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0123});
        vecs.push_back('{1, 4'hB, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 16'h1234});
        vecs.push_back('{1, 4'd5, 0, 0, 0, 0,  1, 0, 1, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 1, 1, 0,  1, 1, 1, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 1, 1, 1,  1, 0, 1, 0, 0, 16'h1234});
        vecs.push_back('{1, 4'd7, 0, 0, 1, 0,  1, 0, 0, 1, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 16'h1234});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 16'h0000});
        vecs.push_back('{1, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{1, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{1, 4'd7, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000});
        vecs.push_back('{1, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0007});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0070});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 16'h0070});
        vecs.push_back('{1, 4'd5, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0070});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 16'h0705});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0705});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0705});
        vecs.push_back('{0, 4'd0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 16'h0705});
        vecs.push_back('{0, 4'd0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 16'h0705});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0705});
        vecs.push_back('{0, 4'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0705});
        vecs.push_back('{0, 4'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0705});

        clearn = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        clearn = 1'b1;

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].sp,
                 vecs[i].tk, vecs[i].az, vecs[i].ld, vecs[i].en, vecs[i].run,
                 vecs[i].dn, vecs[i].er, vecs[i].bufv);

        // countdown from 00:02 against a model counter driving all_zero
        reset_pulse();
        step("rst", 0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k0a", 1, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k0b", 1, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k0c", 1, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k2",  1, 4'd2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("st2", 0, 4'd0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0002);
        step("ld2", 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0002);
        cnt = 2;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 4'd0, 0, 0, i % 2 == 1, cnt == 0);
            @(negedge clk);
            if (done) break;
            chk($sformatf("cd en %0d", i), {15'd0, en}, {15'd0, tick && cnt != 0});
            pulses += int'(en);
            if (tick && cnt != 0) cnt--;
            @(posedge clk); #1;
        end
        chk("cd done", {15'd0, done}, 16'd1);
        chk("cd pulses", 16'(pulses), 16'd2);
        @(posedge clk); #1;
        step("dn tick", 0, 4'd0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 16'h0002);
        step("dn stop", 0, 4'd0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 16'h0002);

        // seconds-tens at its limit is accepted, then reset mid-run
        step("k0d", 1, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k0e", 1, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k5",  1, 4'd5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("k9",  1, 4'd9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0005);
        step("st59", 0, 4'd0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0059);
        step("ld59", 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0059);
        step("run59", 0, 4'd0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 16'h0059);
        clearn = 1'b0;
        drive(0, 4'd0, 0, 0, 1, 0);
        @(posedge clk); #1;
        clearn = 1'b1;
        step("post rst", 0, 4'd0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_entry_ctrl.md
Name: timer_entry_ctrl

Overview:
Control stage directly upstream of the min:sec BCD down-counter chain.
- Collects keypad digits into a 4-digit MM:SS entry buffer.
- Drives the counters' parallel-load strobe and BCD load data, then gates their count enable from a 1 Hz tick.
- Handles start, pause and resume, and stops the chain at 00:00 so it never wraps to 9.
- Sits between keypad/button debouncers and the four mod-10/mod-6 digit counters.

Parameters:
SEC_TENS_MAX, 5, largest legal seconds-tens digit; entry above it is rejected at start
TICK_ACTIVE, 1, polarity of tick input (1 = active-high pulse)

Ports:
clk  input  1  system clock, all state on rising edge
clearn  input  1  synchronous active-low reset
key_valid  input  1  one-cycle strobe, key_digit valid
key_digit  input  4  BCD digit from keypad; codes 10-15 ignored
start  input  1  one-cycle start/resume pulse
stop  input  1  one-cycle stop/pause pulse
tick  input  1  one-cycle 1 Hz pulse from prescaler
all_zero  input  1  AND of all four counter zero flags
loadn  output  1  active-low parallel load to counters
en  output  1  count enable to least-significant counter
data_min_t, data_min_o, data_sec_t, data_sec_o  output  4 each  entry buffer digits, also counter load data
running  output  1  high in RUN
done  output  1  high in DONE
err  output  1  one-cycle pulse on rejected start

Behaviour:
- Reset: clearn sampled low at an edge forces the following, regardless of other inputs.
  - state IDLE, buffer 0000, err 0.
  - Combinational outputs follow from that: loadn 1, en 0, running 0, done 0.
- States: IDLE, LOAD, RUN, PAUSE, DONE. Outputs are Moore except en.
- IDLE
  - key_valid with key_digit<=9 shifts the buffer left: min_t<=min_o, min_o<=sec_t, sec_t<=sec_o, sec_o<=key_digit.
  - key_valid with key_digit>9 is ignored.
  - start with buffer==0000, or with sec_t>SEC_TENS_MAX: stay IDLE, err=1 for one cycle.
  - Any other start goes to LOAD.
  - key_valid and start in the same cycle: the shift happens and start is evaluated on the pre-shift buffer.
- LOAD
  - Lasts exactly one cycle. loadn=0, en=0, data_* hold the buffer.
  - Counters load at the edge leaving LOAD; next state is RUN unconditionally (start/stop ignored).
- RUN
  - en = tick & ~all_zero, combinational; running=1.
  - all_zero=1 at an edge goes to DONE. This has priority over stop; en is 0 in that cycle.
  - Otherwise stop goes to PAUSE. A tick coincident with stop still produces its en pulse.
  - key_valid and start are ignored.
- PAUSE
  - en=0, counters hold.
  - stop goes to IDLE; the buffer is retained, so a new start reloads the same time.
  - Otherwise start goes to RUN with no reload.
  - start and stop together: stop wins.
- DONE
  - done=1, en=0.
  - start or stop goes to IDLE with the buffer cleared to 0000.
  - key_valid is ignored.
- Buffer: written only in IDLE (shift) and on DONE exit (clear). It is frozen in LOAD, RUN and PAUSE.
- Latency: start to loadn low is 1 cycle; start to first possible en is 2 cycles.
- Reset mid-operation (any state): next cycle is IDLE with buffer 0000. Counters are reset by their own clearn.

Decomposition:
- Shared header timer_defs: state encodings (3-bit localparams), BCD digit width 4, SEC_TENS_MAX default.
- Sub-module timer_entry_buf: 16-bit BCD shift/clear register with shift_en, clr, digit-valid filter and four digit outputs.
- FSM and en/loadn logic stay in timer_entry_ctrl.

Test Plan:
- Keys 1,2,3,4 then start -> buffer 12:34; loadn low exactly one cycle after start; running high from the next cycle; en pulses only with tick.
- Keys 0,0,0,2, start, 2 ticks with all_zero driven per the model counter -> en pulses 2 times, then all_zero=1 -> DONE, done=1, en stays 0 on further ticks.
- Keys 0,0,7,0 then start -> err pulse 1 cycle, state IDLE, loadn never low. Start with empty buffer -> err.
- RUN, stop coincident with tick -> one en pulse, then PAUSE. start -> RUN with no loadn pulse. stop, stop -> IDLE with buffer still 12:34.
- key_digit=4'hB strobe in IDLE -> buffer unchanged. Keys during RUN -> buffer unchanged.
- clearn low for one edge during RUN -> IDLE, buffer 0000, en 0, running 0 on the next cycle. Start and stop in the same cycle in PAUSE -> IDLE.
